// File: rtl/fifo_rd_stream_pkg.sv
// Shared types and elaboration helpers for the FIFO read-side stream adapter.
package fifo_stream_pkg;

  // Completed-packet counter type; wraps naturally at 2^16.
  typedef logic [15:0] pkt_cnt_t;

  // Number of bits needed to hold values 0..n-1, never less than one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 32'sd0;
    while ((32'sd1 <<< r) < n) begin
      r = r + 32'sd1;
    end
    return (r < 32'sd1) ? 32'sd1 : r;
  endfunction

  // Output buffer depth: enough entries to cover the FIFO read latency plus
  // one beat in the output register and one in the return path.
  function automatic int buf_depth(input int lat);
    return lat + 32'sd2;
  endfunction

endpackage

// File: rtl/fifo_rd_stream_obuf.sv
// Small circular buffer between the FIFO read port and the stream output.
// Depth need not be a power of two, so pointers wrap by explicit compare.
module stream_obuf
  import fifo_stream_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                flush,
  input  logic                                push,
  input  logic [WIDTH-1:0]                    push_data,
  input  logic                                pop,
  output logic [clog2_min1(DEPTH+32'sd1)-1:0] occ,
  output logic                                not_empty,
  output logic [WIDTH-1:0]                    head_data
);

  localparam int PW = clog2_min1(DEPTH);
  localparam int OW = clog2_min1(DEPTH + 32'sd1);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 32'sd1);
  localparam logic [OW-1:0] OCC_FULL = OW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [OW-1:0]    r_occ;
  logic             r_not_empty;
  logic [OW-1:0]    w_occ_nxt;
  logic             w_pop_ok;
  logic             w_push_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? {PW{1'b0}} : (p + PW'(1'b1));
  endfunction

  // Qualify push/pop against occupancy and work out the next occupancy.
  always_comb begin
    w_pop_ok  = pop && (r_occ != {OW{1'b0}});
    w_push_ok = push && ((r_occ != OCC_FULL) || w_pop_ok);
    w_occ_nxt = r_occ;
    case ({w_push_ok, w_pop_ok})
      2'b10:   w_occ_nxt = r_occ + OW'(1'b1);
      2'b01:   w_occ_nxt = r_occ - OW'(1'b1);
      default: w_occ_nxt = r_occ;
    endcase
  end

  // Pointer and occupancy registers; flush empties the buffer at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head      <= {PW{1'b0}};
      r_tail      <= {PW{1'b0}};
      r_occ       <= {OW{1'b0}};
      r_not_empty <= 1'b0;
    end else if (flush) begin
      r_head      <= {PW{1'b0}};
      r_tail      <= {PW{1'b0}};
      r_occ       <= {OW{1'b0}};
      r_not_empty <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_tail <= ptr_inc(r_tail);
      end
      if (w_pop_ok) begin
        r_head <= ptr_inc(r_head);
      end
      r_occ       <= w_occ_nxt;
      r_not_empty <= (w_occ_nxt != {OW{1'b0}});
    end
  end

  // Storage array; cleared on reset so the head reads as zero afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {WIDTH{1'b0}};
      end
    end else if (w_push_ok && !flush) begin
      r_mem[r_tail] <= push_data;
    end
  end

  assign occ       = r_occ;
  assign not_empty = r_not_empty;
  assign head_data = r_mem[r_head];

endmodule

// File: rtl/fifo_rd_stream.sv
// Turns a FIFO read port (empty/rd_en/data_out) into a valid/ready stream
// with fixed-length packet framing. Reads are issued on credit so the small
// output buffer can always absorb data that is still in flight.
module fifo_rd_stream
  import fifo_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 0,
  parameter int PKT_LEN    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  input  logic                  flush,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output pkt_cnt_t              pkt_count
);

  localparam int BUF_DEPTH = buf_depth(RD_LATENCY);
  localparam int OW        = clog2_min1(BUF_DEPTH + 32'sd1);
  localparam int UW        = OW + 32'sd1;
  localparam int BW        = clog2_min1(PKT_LEN);
  localparam logic [BW-1:0] LAST_BEAT  = BW'(PKT_LEN - 32'sd1);
  localparam logic [UW-1:0] CREDIT_MAX = UW'(BUF_DEPTH);

  if ((RD_LATENCY != 32'sd0) && (RD_LATENCY != 32'sd1)) begin : g_bad_latency
    $error("fifo_rd_stream: RD_LATENCY must be 0 or 1");
  end

  if (PKT_LEN < 32'sd1) begin : g_bad_pkt_len
    $error("fifo_rd_stream: PKT_LEN must be at least 1");
  end

  logic [OW-1:0]         w_occ;
  logic                  w_not_empty;
  logic [DATA_WIDTH-1:0] w_head;
  logic                  w_inflight;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_last;
  logic [UW-1:0]         w_used;
  logic [BW-1:0]         r_beat_cnt;
  pkt_cnt_t              r_pkt_count;

  // Issue a read only while buffered plus in-flight words leave a free slot;
  // this is the only back-pressure path towards the FIFO.
  always_comb begin
    w_used     = UW'(w_occ) + UW'(w_inflight);
    fifo_rd_en = !fifo_empty && !flush && (w_used < CREDIT_MAX);
  end

  if (RD_LATENCY == 32'sd1) begin : g_lat1
    logic r_rd_pipe;

    // Track the read issued last cycle; its data is on fifo_data now.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_rd_pipe <= 1'b0;
      end else begin
        r_rd_pipe <= fifo_rd_en;
      end
    end

    assign w_inflight = r_rd_pipe;
    // A word returning during flush belongs to the discarded stream.
    assign w_push     = r_rd_pipe && !flush;
  end else begin : g_lat0
    assign w_inflight = 1'b0;
    assign w_push     = fifo_rd_en;
  end

  assign w_pop = w_not_empty && m_ready && !flush;

  stream_obuf #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_obuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (w_push),
    .push_data (fifo_data),
    .pop       (w_pop),
    .occ       (w_occ),
    .not_empty (w_not_empty),
    .head_data (w_head)
  );

  assign w_last = w_not_empty && (r_beat_cnt == LAST_BEAT);

  // Beat position within the packet and the completed-packet count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat_cnt  <= {BW{1'b0}};
      r_pkt_count <= 16'd0;
    end else if (flush) begin
      r_beat_cnt  <= {BW{1'b0}};
    end else if (w_pop) begin
      if (w_last) begin
        r_beat_cnt  <= {BW{1'b0}};
        r_pkt_count <= r_pkt_count + 16'd1;
      end else begin
        r_beat_cnt  <= r_beat_cnt + BW'(1'b1);
      end
    end
  end

  assign m_valid   = w_not_empty;
  assign m_data    = w_head;
  assign m_last    = w_last;
  assign pkt_count = r_pkt_count;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: one instance per read latency, each fed by a
// behavioural FIFO, checked every cycle against a queue-level model of the
// buffer, credit rule and packet framing.
module tb_fifo_rd_stream;

  localparam int DW = 8;
  localparam int PL = 4;
  localparam int FM = 1024;

  logic clk;
  logic rst_n;
  logic flush;
  logic m_ready;
  logic fe0, fe1, rd0, rd1, v0, v1, l0, l1;
  logic [DW-1:0] fd0, fd1, md0, md1;
  logic [15:0] pc0, pc1;

  fifo_rd_stream #(.DATA_WIDTH(DW), .RD_LATENCY(0), .PKT_LEN(PL)) u_dut_lat0 (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fe0), .fifo_data(fd0), .fifo_rd_en(rd0),
    .flush(flush), .m_valid(v0), .m_ready(m_ready), .m_data(md0), .m_last(l0),
    .pkt_count(pc0)
  );

  fifo_rd_stream #(.DATA_WIDTH(DW), .RD_LATENCY(1), .PKT_LEN(PL)) u_dut_lat1 (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fe1), .fifo_data(fd1), .fifo_rd_en(rd1),
    .flush(flush), .m_valid(v1), .m_ready(m_ready), .m_data(md1), .m_last(l1),
    .pkt_count(pc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_pass;

  // Behavioural FIFOs (index 0: fall-through, index 1: one-cycle latency).
  logic [DW-1:0] fmem [2][FM];
  int fwr [2];
  int frd [2];
  logic [DW-1:0] dout1;

  // Reference model: words held by the adapter, in order, plus in-flight read.
  logic [DW-1:0] bq [2][8];
  int bcnt [2];
  int infl [2];
  logic [DW-1:0] infl_val [2];
  int beats [2];
  int pkts [2];
  int nxfer [2];

  int cyc;
  int rdy_mode;
  int emp_mode;
  logic force_empty;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      fwr[d] = 0; frd[d] = 0; bcnt[d] = 0; infl[d] = 0;
      beats[d] = 0; pkts[d] = 0; nxfer[d] = 0; infl_val[d] = '0;
    end
    dout1 = '0;
  endtask

  task automatic load(input int n, input int first, input bit rnd);
    logic [DW-1:0] w;
    for (int i = 0; i < n; i++) begin
      w = rnd ? DW'($urandom_range(0, 255)) : DW'(first + i);
      for (int d = 0; d < 2; d++) begin
        fmem[d][fwr[d] % FM] = w;
        fwr[d]++;
      end
    end
  endtask

  task automatic drive_env();
    case (rdy_mode)
      0: m_ready = 1'b1;
      1: m_ready = 1'b0;
      2: m_ready = ((cyc % 2) == 0);
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
    case (emp_mode)
      1: force_empty = ((cyc % 3) == 2);
      2: force_empty = ($urandom_range(0, 3) == 0);
      default: force_empty = 1'b0;
    endcase
    fe0 = (fwr[0] == frd[0]) || force_empty;
    fd0 = (fwr[0] != frd[0]) ? fmem[0][frd[0] % FM] : '0;
    fe1 = (fwr[1] == frd[1]) || force_empty;
    fd1 = dout1;
  endtask

  task automatic model_step(input int d, input logic emp, input logic rd, input logic v,
                            input logic lst, input logic [DW-1:0] dat, input logic [15:0] pc);
    logic e_rd, e_v, e_l;
    logic [DW-1:0] w;
    e_rd = !emp && !flush && ((bcnt[d] + infl[d]) < (d + 2));
    e_v  = (bcnt[d] != 0);
    e_l  = e_v && (beats[d] == PL - 1);
    chk($sformatf("fifo_rd_en%0d", d), 32'(rd), 32'(e_rd));
    chk($sformatf("m_valid%0d", d), 32'(v), 32'(e_v));
    chk($sformatf("m_last%0d", d), 32'(lst), 32'(e_l));
    if (e_v) chk($sformatf("m_data%0d", d), 32'(dat), 32'(bq[d][0]));
    chk($sformatf("pkt_count%0d", d), 32'(pc), 32'(16'(pkts[d])));
    if (flush) begin
      bcnt[d] = 0; beats[d] = 0; infl[d] = 0;
    end else begin
      if (e_v && m_ready) begin
        for (int k = 0; k < 7; k++) bq[d][k] = bq[d][k+1];
        bcnt[d]--;
        if (e_l) begin beats[d] = 0; pkts[d]++; end
        else beats[d]++;
      end
      if (infl[d] != 0) begin
        bq[d][bcnt[d]] = infl_val[d]; bcnt[d]++; infl[d] = 0;
      end
      if (e_rd) begin
        w = fmem[d][frd[d] % FM];
        frd[d]++;
        if (d == 0) begin bq[d][bcnt[d]] = w; bcnt[d]++; end
        else begin infl[d] = 1; infl_val[d] = w; dout1 = w; end
      end
    end
  endtask

  task automatic cycle();
    drive_env();
    @(negedge clk);
    if (v0 && m_ready && !flush) nxfer[0]++;
    if (v1 && m_ready && !flush) nxfer[1]++;
    model_step(0, fe0, rd0, v0, l0, md0, pc0);
    model_step(1, fe1, rd1, v1, l1, md1, pc1);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rd0"}, 32'(rd0), 32'd0);
    chk({tag, "_rd1"}, 32'(rd1), 32'd0);
    chk({tag, "_valid0"}, 32'(v0), 32'd0);
    chk({tag, "_valid1"}, 32'(v1), 32'd0);
    chk({tag, "_data0"}, 32'(md0), 32'd0);
    chk({tag, "_data1"}, 32'(md1), 32'd0);
    chk({tag, "_last0"}, 32'(l0), 32'd0);
    chk({tag, "_last1"}, 32'(l1), 32'd0);
    chk({tag, "_pkt0"}, 32'(pc0), 32'd0);
    chk({tag, "_pkt1"}, 32'(pc1), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before the bench finished");
    $fatal(1);
  end

  initial begin
    int base0, base1;
    bit reached;
    n_chk = 0; n_pass = 0; cyc = 0; rdy_mode = 0; emp_mode = 0; force_empty = 1'b0;
    rst_n = 1'b0; flush = 1'b0; m_ready = 1'b0;
    model_reset();
    fe0 = 1'b1; fe1 = 1'b1; fd0 = '0; fd1 = '0;
    #1;
    chk_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Preloaded 0x01..0x08, sink always ready: latency and gap-free streaming.
    load(8, 8'h01, 1'b0);
    nxfer[0] = 0; nxfer[1] = 0;
    run(9);
    chk("t1_beats_lat0", 32'(nxfer[0]), 32'd8);
    chk("t1_beats_lat1", 32'(nxfer[1]), 32'd7);
    run(3);
    chk("t1_total_lat1", 32'(nxfer[1]), 32'd8);
    chk("t1_pkts_lat0", 32'(pc0), 32'd2);
    chk("t1_pkts_lat1", 32'(pc1), 32'd2);

    // Back-pressure mid-stream: reads must stop once the buffer is committed.
    load(8, 8'h11, 1'b0);
    rdy_mode = 0; run(3);
    rdy_mode = 1; run(5);
    drive_env();
    #1;
    chk("bp_rd_en_lat0", 32'(rd0), 32'd0);
    chk("bp_rd_en_lat1", 32'(rd1), 32'd0);
    chk("bp_valid_lat0", 32'(v0), 32'd1);
    chk("bp_valid_lat1", 32'(v1), 32'd1);
    rdy_mode = 0; run(16);

    // Flush the cycle after a read is issued; first word is lost.
    base0 = pkts[0]; base1 = pkts[1];
    load(8, 8'h21, 1'b0);
    run(1);
    flush = 1'b1; run(1); flush = 1'b0;
    drive_env();
    #1;
    chk("flush_valid_lat0", 32'(v0), 32'd0);
    chk("flush_valid_lat1", 32'(v1), 32'd0);
    run(14);
    chk("flush_pkts_lat0", 32'(pc0), 32'(16'(base0 + 1)));
    chk("flush_pkts_lat1", 32'(pc1), 32'(16'(base1 + 1)));
    flush = 1'b1; run(1); flush = 1'b0;

    // Alternating ready with the FIFO looking empty every third cycle.
    base0 = pkts[0]; base1 = pkts[1];
    emp_mode = 1; rdy_mode = 2;
    load(12, 8'h41, 1'b0);
    run(60);
    chk("alt_pkts_lat0", 32'(pc0), 32'(16'(base0 + 3)));
    chk("alt_pkts_lat1", 32'(pc1), 32'(16'(base1 + 3)));
    emp_mode = 0;

    // Asynchronous reset after two beats of a packet.
    rdy_mode = 0;
    load(8, 8'h61, 1'b0);
    reached = 1'b0;
    for (int i = 0; i < 20 && !reached; i++) begin
      cycle();
      if (beats[0] == 2) reached = 1'b1;
    end
    chk("rst_mid_reached", 32'(reached), 32'd1);
    rst_n = 1'b0;
    model_reset();
    fe0 = 1'b1; fe1 = 1'b1; fd0 = '0; fd1 = '0;
    #1;
    chk_zero("rst_mid");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    load(8, 8'h71, 1'b0);
    run(14);
    chk("rst_refill_pkts_lat0", 32'(pc0), 32'd2);
    chk("rst_refill_pkts_lat1", 32'(pc1), 32'd2);

    // Randomised traffic, sink stalls, empty glitches and occasional flushes.
    rdy_mode = 3; emp_mode = 2;
    for (int i = 0; i < 400; i++) begin
      if (($urandom_range(0, 2) == 0) && ((fwr[0] - frd[0]) < 16)) begin
        load(int'($urandom_range(1, 3)), 0, 1'b1);
      end
      flush = ($urandom_range(0, 29) == 0);
      cycle();
      flush = 1'b0;
    end
    rdy_mode = 0; emp_mode = 0;
    run(40);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
- Downstream consumer of fifo_sync_top's read port.
- Converts the FIFO's empty/rd_en/data_out interface into a valid/ready stream master with packet framing.
- Hides FIFO read latency behind a small internal output buffer, tracking in-flight reads by credit.
- Sustains one beat per cycle when the sink is always ready, and frames fixed-length packets with m_last.

Parameters:
- DATA_WIDTH, 8, width of FIFO data and stream data.
- RD_LATENCY, 0, FIFO read latency: 0 = data_out valid in the same cycle as rd_en (first-word fall-through); 1 = data_out valid the cycle after rd_en. Only 0 and 1 are legal; elaboration error otherwise.
- PKT_LEN, 4, beats per packet; minimum 1; elaboration error if 0.

Ports:
- clk  input  1  single clock.
- rst_n  input  1  reset; asynchronous assert, active-low.
- fifo_empty  input  1  FIFO empty flag.
- fifo_data  input  DATA_WIDTH  FIFO data_out.
- fifo_rd_en  output  1  read strobe to the FIFO rd_en.
- flush  input  1  synchronous clear of buffered/in-flight data and framing.
- m_valid  output  1  stream beat valid.
- m_ready  input  1  sink ready.
- m_data  output  DATA_WIDTH  stream data.
- m_last  output  1  final beat of a packet.
- pkt_count  output  16  completed packets, wraps modulo 2^16.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - fifo_rd_en=0, m_valid=0, m_data=0, m_last=0, pkt_count=0.
  - Buffer empty, in-flight counter 0, beat counter 0.
- Buffer:
  - Circular, BUF_DEPTH = RD_LATENCY+2 entries (localparam).
  - occ counts stored entries, 0..BUF_DEPTH.
  - inflight counts issued reads whose data has not yet returned: 0..1 when RD_LATENCY=1, always 0 when RD_LATENCY=0.
- Read issue:
  - fifo_rd_en = !fifo_empty && !flush && (occ + inflight) < BUF_DEPTH.
  - Combinational from fifo_empty and registered state only; never depends on m_ready.
- Capture:
  - RD_LATENCY=0: fifo_data is written into the buffer at the same edge where fifo_rd_en is high.
  - RD_LATENCY=1: fifo_data is written at the edge after the rd_en cycle. A 1-bit pipe register tracks the return.
- Stream output:
  - m_valid = (occ != 0). m_data is the head entry, registered, not combinational from fifo_data.
  - Latency from fifo_empty falling to m_valid rising: 1 cycle (RD_LATENCY=0), 2 cycles (RD_LATENCY=1).
- Handshake:
  - A beat transfers when m_valid && m_ready.
  - While m_valid && !m_ready, m_data and m_last hold stable and m_valid stays high.
  - Order is strictly preserved; no beat is dropped or duplicated.
- Simultaneous events:
  - Push and pop in the same cycle leaves occ unchanged.
  - Credit accounting does not count a same-cycle pop, which is conservative.
  - Full throughput is still achieved because BUF_DEPTH absorbs the latency.
- Framing:
  - beat_cnt (clog2(PKT_LEN) bits, minimum 1 bit) increments on each transfer.
  - m_last = m_valid && (beat_cnt == PKT_LEN-1).
  - On a transfer with m_last, beat_cnt returns to 0 and pkt_count increments.
  - PKT_LEN=1 gives m_last on every beat.
- Buffer full (occ + inflight == BUF_DEPTH): fifo_rd_en=0 even if fifo_empty=0. FIFO back-pressure is achieved solely this way.
- FIFO empty: no reads are issued; buffered data keeps draining.
- flush=1 for one cycle:
  - occ, pointers and beat_cnt clear at that edge; m_valid=0 the next cycle; no transfer is counted in the flush cycle.
  - fifo_rd_en is forced 0 during flush.
  - Data returning in the cycle after flush (RD_LATENCY=1, read issued before flush) is discarded via the inflight pipe.
  - pkt_count is not cleared.
- Reset mid-packet: everything clears immediately. The FIFO is reset by the same rst_n, so no stale data is expected afterwards.
- Pointer wrap: head/tail pointers wrap modulo BUF_DEPTH; BUF_DEPTH=3 requires explicit wrap compare, not power-of-two masking.

Decomposition:
- Package fifo_stream_pkg:
  - function clog2_min1.
  - localparam helper BUF_DEPTH(lat) = lat+2.
  - typedef pkt_cnt_t (logic [15:0]).
- One natural sub-module: stream_obuf, a parameterised-depth circular buffer with push/pop/occ/flush.
- Framing and credit logic stay in the top.

Test Plan:
- RD_LATENCY=0, PKT_LEN=4, FIFO preloaded 0x01..0x08, m_ready=1 -> m_valid high from cycle 1, eight consecutive beats 0x01..0x08, m_last on 0x04 and 0x08, pkt_count=2.
- RD_LATENCY=1, same data, m_ready=1 -> first beat 2 cycles after fifo_empty falls, then one beat per cycle with no bubbles, order 0x01..0x08.
- Back-pressure: m_ready=0 for 5 cycles mid-stream -> m_data holds its value, fifo_rd_en drops once occ+inflight=BUF_DEPTH, no loss or duplication after release.
- Alternating m_ready 1/0 with FIFO empty every third cycle -> output sequence matches the FIFO write order exactly; pkt_count matches floor(beats/PKT_LEN).
- RD_LATENCY=1, flush asserted the cycle after a read is issued -> returning word is discarded, m_valid=0 the next cycle, the next packet starts at beat_cnt=0 with m_last on its 4th beat.
- rst_n pulsed low mid-packet (after 2 of 4 beats) -> all outputs are 0 immediately (asynchronous), pkt_count=0, the next refilled stream frames from beat 0.
